// File: rtl/masked_sbox_scheduler.sv
// Streams one 2-share AES state byte-by-byte through an external pipelined TI
// S-box and reassembles the returned shares in issue order.
module masked_sbox_scheduler #(
  parameter int SBOX_LAT = 3,
  parameter int RND_W    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_s0,
  input  logic [127:0]     in_s1,
  input  logic             rnd_valid,
  input  logic [RND_W-1:0] rnd_data,
  output logic             rnd_ack,
  output logic             sb_in_valid,
  output logic [7:0]       sb_in_s0,
  output logic [7:0]       sb_in_s1,
  output logic [RND_W-1:0] sb_rnd,
  input  logic [7:0]       sb_out_s0,
  input  logic [7:0]       sb_out_s1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_s0,
  output logic [127:0]     out_s1,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [15:0][7:0]    sh0_q, sh0_d, sh1_q, sh1_d;
  logic [15:0][7:0]    res0_q, res0_d, res1_q, res1_d;
  logic [4:0]          fc_q, fc_d, cc_q, cc_d;
  logic [SBOX_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic                issue, cap;

  always_comb begin
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    fc_d    = fc_q;
    cc_d    = cc_q;

    issue = (state_q == FEED) && rnd_valid && (fc_q < 5'd16);
    cap   = vld_pipe_q[SBOX_LAT-1] && ((state_q == FEED) || (state_q == DRAIN)) &&
            (cc_q < 5'd16);

    // Tag line mirrors the S-box pipeline; its tail marks a returning byte.
    vld_pipe_d[0] = issue;
    for (int i = 1; i < SBOX_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    if (issue) fc_d = fc_q + 5'd1;
    if (cap) begin
      res0_d[cc_q[3:0]] = sb_out_s0;
      res1_d[cc_q[3:0]] = sb_out_s1;
      cc_d              = cc_q + 5'd1;
    end

    case (state_q)
      IDLE: if (in_valid) begin
        sh0_d   = in_s0;
        sh1_d   = in_s1;
        fc_d    = '0;
        cc_d    = '0;
        state_d = FEED;
      end
      FEED:    if (issue && fc_q == 5'd15) state_d = DRAIN;
      DRAIN:   if (cap && cc_q == 5'd15) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh0_q      <= '0;
      sh1_q      <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
      fc_q       <= '0;
      cc_q       <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      fc_q       <= fc_d;
      cc_q       <= cc_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Byte select is the registered fc; shares stay in separate datapaths.
  assign sb_in_valid = issue;
  assign rnd_ack     = issue;
  assign sb_in_s0    = issue ? sh0_q[fc_q[3:0]] : 8'h00;
  assign sb_in_s1    = issue ? sh1_q[fc_q[3:0]] : 8'h00;
  assign sb_rnd      = issue ? rnd_data : '0;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_s0    = res0_q;
  assign out_s1    = res1_q;
endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Directed bench for masked_sbox_scheduler at S-box latencies 3, 1 and 8, each
// DUT paired with a behavioural masked AES S-box pipeline.
module tb_masked_sbox_scheduler;
  localparam int N = 3;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid[N], in_ready[N], rnd_valid[N], rnd_ack[N];
  logic         sb_in_valid[N], out_valid[N], out_ready[N], busy[N];
  logic [127:0] in_s0[N], in_s1[N], out_s0[N], out_s1[N];
  logic [17:0]  rnd_data[N], sb_rnd[N];
  logic [7:0]   sb_in_s0[N], sb_in_s1[N], sb_out_s0[N], sb_out_s1[N];

  int checks, failures;
  int gate_err;
  int ack_cnt[N];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : (g == 1) ? 1 : 8;
    logic [15:0] pipe[8];

    masked_sbox_scheduler #(.SBOX_LAT(L), .RND_W(18)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_s0      (in_s0[g]),
      .in_s1      (in_s1[g]),
      .rnd_valid  (rnd_valid[g]),
      .rnd_data   (rnd_data[g]),
      .rnd_ack    (rnd_ack[g]),
      .sb_in_valid(sb_in_valid[g]),
      .sb_in_s0   (sb_in_s0[g]),
      .sb_in_s1   (sb_in_s1[g]),
      .sb_rnd     (sb_rnd[g]),
      .sb_out_s0  (sb_out_s0[g]),
      .sb_out_s1  (sb_out_s1[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_s0     (out_s0[g]),
      .out_s1     (out_s1[g]),
      .busy       (busy[g])
    );

    // Output remasked with randomness-derived mask so shares differ from input.
    always @(posedge clk) begin
      pipe[0] <= {sbox(sb_in_s0[g] ^ sb_in_s1[g]) ^ sb_rnd[g][7:0], sb_rnd[g][7:0]};
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign sb_out_s0[g] = pipe[L-1][15:8];
    assign sb_out_s1[g] = pipe[L-1][7:0];
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!sb_in_valid[k] && (sb_in_s0[k] != 8'h00 || sb_in_s1[k] != 8'h00 ||
                              sb_rnd[k] != 18'h0)) gate_err++;
      if (rnd_ack[k]) ack_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with DUT k idle; returns #1 after a rising edge.
  task automatic run_state(input int k, input logic [127:0] a, input logic [127:0] b,
                           input logic [31:0] bub, input int hold, input bit offer,
                           input int exp_lat);
    int lat, a0;
    bit stable;
    logic [127:0] o0, o1;
    chk("accept_ready", in_ready[k], 1);
    in_valid[k]  = 1'b1;
    in_s0[k]     = a;
    in_s1[k]     = b;
    out_ready[k] = (hold == 0);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_s0[k]    = '0;
    in_s1[k]    = '0;
    a0  = ack_cnt[k];
    lat = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      rnd_valid[k] = (cyc < 32) ? !bub[cyc] : 1'b1;
      rnd_data[k]  = 18'($urandom);
      @(negedge clk);
      if (out_valid[k]) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", lat, exp_lat);
    chk("rnd_acks", ack_cnt[k] - a0, 16);
    chk("unmasked_result", out_s0[k] ^ out_s1[k], EXP);
    chk("done_flags", {in_ready[k], busy[k]}, 2'b01);
    o0 = out_s0[k];
    o1 = out_s1[k];
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        in_valid[k] = offer;
        in_s0[k]    = ~a;
        @(negedge clk);
        if (!(out_valid[k] === 1'b1 && in_ready[k] === 1'b0 && busy[k] === 1'b1 &&
              out_s0[k] === o0 && out_s1[k] === o1)) stable = 1'b0;
      end
      chk("done_hold_stable", stable, 1);
      @(posedge clk); #1;
      in_valid[k]  = 1'b0;
      in_s0[k]     = '0;
      out_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    rnd_valid[k] = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {out_valid[k], in_ready[k], busy[k]}, 3'b010);
    chk("out_keep", {out_s0[k] ^ o0, out_s1[k] ^ o1}, '0);
    @(posedge clk); #1;
  endtask

  logic [127:0] m;

  initial begin
    checks   = 0;
    failures = 0;
    gate_err = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      in_s0[k]     = '0;
      in_s1[k]     = '0;
      rnd_valid[k] = 1'b0;
      rnd_data[k]  = '0;
      out_ready[k] = 1'b0;
      ack_cnt[k]   = 0;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      chk("reset_flags", {in_ready[k], out_valid[k], busy[k], sb_in_valid[k], rnd_ack[k]},
          5'b10000);
      chk("reset_out", out_s0[k] | out_s1[k], '0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain state, zero mask share.
    run_state(0, PT, 128'h0, 32'h0, 2, 1'b0, 20);

    // Randomly masked input shares.
    m = {$urandom, $urandom, $urandom, $urandom};
    run_state(0, PT ^ m, m, 32'h0, 1, 1'b0, 20);

    // Three randomness bubbles, the last on the byte-15 slot; out_ready already high.
    run_state(0, PT, 128'h0, 32'h0004_0208, 0, 1'b0, 23);

    // Long DONE hold with an ignored in_valid offer.
    m = {$urandom, $urandom, $urandom, $urandom};
    run_state(0, PT ^ m, m, 32'h0, 10, 1'b1, 20);

    // Latency 1 and 8, back to back.
    m = {$urandom, $urandom, $urandom, $urandom};
    run_state(1, PT ^ m, m, 32'h0, 0, 1'b0, 18);
    run_state(1, PT, 128'h0, 32'h0, 0, 1'b0, 18);
    m = {$urandom, $urandom, $urandom, $urandom};
    run_state(2, PT ^ m, m, 32'h0, 0, 1'b0, 25);
    run_state(2, PT, 128'h0, 32'h0, 1, 1'b0, 25);

    // Reset in DRAIN with bytes still in flight.
    in_valid[0] = 1'b1;
    in_s0[0]    = PT;
    in_s1[0]    = 128'h0;
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    rnd_valid[0] = 1'b1;
    for (int c = 0; c < 17; c++) begin
      rnd_data[0] = 18'($urandom);
      @(posedge clk); #1;
    end
    chk("pre_reset_drain", {busy[0], sb_in_valid[0], out_valid[0]}, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {in_ready[0], out_valid[0], busy[0], sb_in_valid[0], rnd_ack[0]},
        5'b10000);
    chk("async_reset_out", out_s0[0] | out_s1[0], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
    end
    rnd_valid[0] = 1'b0;
    chk("no_spurious_capture", out_s0[0] | out_s1[0], '0);
    chk("post_reset_idle", {in_ready[0], out_valid[0], busy[0]}, 3'b100);

    chk("issue_gating", gate_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
